// File: rtl/pm_arbiter_if.sv
// pm_arbiter_if: bundles the fetch, data and program-memory handshake
// signals of pm_arbiter. The slave modport is the arbiter's view; the master
// modport is the view of the environment (fetch unit, load unit and PM).
interface pm_arbiter_if #(
  parameter int XLEN = 32
);
  // Fetch requester
  logic            f_req_i;
  logic [XLEN-1:0] f_addr_i;
  logic            f_gnt_o;
  logic            f_flush_i;
  logic            f_rvalid_o;
  logic [XLEN-1:0] f_rdata_o;

  // Data / vector load requester
  logic            d_req_i;
  logic [XLEN-1:0] d_addr_i;
  logic            d_gnt_o;
  logic            d_rvalid_o;
  logic [XLEN-1:0] d_rdata_o;

  // Program-memory read port
  logic            pm_rd_o;
  logic [XLEN-1:0] pm_addr_o;
  logic            pm_ready_i;
  logic            pm_rvalid_i;
  logic [XLEN-1:0] pm_rdata_i;

  modport slave (
    input  f_req_i, f_addr_i, f_flush_i,
    input  d_req_i, d_addr_i,
    input  pm_ready_i, pm_rvalid_i, pm_rdata_i,
    output f_gnt_o, f_rvalid_o, f_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output pm_rd_o, pm_addr_o
  );

  modport master (
    output f_req_i, f_addr_i, f_flush_i,
    output d_req_i, d_addr_i,
    output pm_ready_i, pm_rvalid_i, pm_rdata_i,
    input  f_gnt_o, f_rvalid_o, f_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  pm_rd_o, pm_addr_o
  );
endinterface

// File: rtl/pm_arbiter.sv
// pm_arbiter: shares the single program-memory read port between the
// instruction fetch unit and the data/vector load requester.
//
// Requests are arbitrated every cycle; each accepted read pushes a tag
// {src, discard} into an in-order FIFO of depth MAX_OUT, and each PM
// response pops the head tag to route the data back to its originator.
// A fetch flush marks every in-flight fetch tag as discarded so the stale
// fetch responses are silently dropped when they return.
//
// Optional feature macro PM_ARB_RR_EN:
//   defined     -> round-robin between fetch and data using a `last` register
//   not defined -> fixed priority, data always wins over fetch
module pm_arbiter #(
  parameter int XLEN    = 32,
  parameter int MAX_OUT = 4    // power of two, >= 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  pm_arbiter_if.slave                bus,
  output logic [$clog2(MAX_OUT):0]   outstanding_o,
  output logic                       err_o
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUT);

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

  typedef struct packed {
    src_e src;
    logic discard;
  } tag_t;

  localparam tag_t TAG_RESET = '{src: SRC_DATA, discard: 1'b0};

  // Registered state
  tag_t             fifo_q [MAX_OUT];
  tag_t             fifo_d [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`ifdef PM_ARB_RR_EN
  src_e             last_q, last_d;
`endif

  // Combinational arbitration / routing signals
  logic             f_elig, d_elig;
  logic             win_fetch, win_data;
  logic             full, empty;
  logic             pm_rd;
  logic [XLEN-1:0]  pm_addr;
  logic             f_gnt, d_gnt;
  logic             push, pop;
  tag_t             head;
  logic             f_rvalid, d_rvalid;

  // Request eligibility, winner selection and grant generation
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    f_elig  = bus.f_req_i & ~bus.f_flush_i;
    d_elig  = bus.d_req_i;
`ifdef PM_ARB_RR_EN
    // On a tie the requester that was not granted last wins.
    win_fetch = f_elig & (~d_elig | (last_q == SRC_DATA));
`else
    // Fixed priority: fetch only wins when data is not asking.
    win_fetch = f_elig & ~d_elig;
`endif
    win_data = d_elig & ~win_fetch;
    // Full uses registered occupancy, so a same-cycle pop never frees a slot.
    full     = (cnt_q == FULL_CNT);
    pm_rd    = (f_elig | d_elig) & ~full;
    pm_addr  = '0;
    if (win_fetch) begin
      pm_addr = bus.f_addr_i;
    end else if (win_data) begin
      pm_addr = bus.d_addr_i;
    end
    f_gnt = win_fetch & pm_rd & bus.pm_ready_i;
    d_gnt = win_data  & pm_rd & bus.pm_ready_i;
    push  = f_gnt | d_gnt;
  end

  // Response routing from the head tag, zero added latency
  always_comb begin
    empty    = (cnt_q == '0);
    head     = fifo_q[rd_ptr_q];
    pop      = bus.pm_rvalid_i & ~empty;
    // A fetch response popped in a flush cycle is stale as well.
    f_rvalid = pop & (head.src == SRC_FETCH) & ~head.discard & ~bus.f_flush_i;
    d_rvalid = pop & (head.src == SRC_DATA);
  end

  // Next-state for tag FIFO, pointers, occupancy, error flag and `last`
  always_comb begin
    fifo_d = fifo_q;
    // Flush marks every fetch tag; invalid slots are overwritten on push.
    if (bus.f_flush_i) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (fifo_q[i].src == SRC_FETCH) begin
          fifo_d[i].discard = 1'b1;
        end
      end
    end
    // Push after the flush marking so a freshly granted tag is never discarded.
    if (push) begin
      fifo_d[wr_ptr_q] = '{src: (f_gnt ? SRC_FETCH : SRC_DATA), discard: 1'b0};
    end
    // Pointers are PTR_W wide, so they wrap modulo MAX_OUT by themselves.
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    // A response with nothing outstanding is a protocol error; it sticks.
    err_d    = err_q | (bus.pm_rvalid_i & empty);
`ifdef PM_ARB_RR_EN
    last_d = last_q;
    if (f_gnt) begin
      last_d = SRC_FETCH;
    end else if (d_gnt) begin
      last_d = SRC_DATA;
    end
`endif
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of statement order.
    if (rst_i) begin
      // NOTE: the tag storage is reset too; it is only MAX_OUT two-bit entries
      // and a defined value keeps the flush marking free of X propagation.
      for (int i = 0; i < MAX_OUT; i++) begin
        fifo_q[i] <= TAG_RESET;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
`ifdef PM_ARB_RR_EN
      last_q   <= SRC_DATA;
`endif
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`ifdef PM_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  // Outputs
  assign bus.f_gnt_o    = f_gnt;
  assign bus.d_gnt_o    = d_gnt;
  assign bus.pm_rd_o    = pm_rd;
  assign bus.pm_addr_o  = pm_addr;
  assign bus.f_rvalid_o = f_rvalid;
  assign bus.d_rvalid_o = d_rvalid;
  assign bus.f_rdata_o  = bus.pm_rdata_i;
  assign bus.d_rdata_o  = bus.pm_rdata_i;
  assign outstanding_o  = cnt_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_pm_arbiter.sv
// tb_pm_arbiter: directed, self-checking bench for pm_arbiter (MAX_OUT=4).
// Each scenario task drives a table of per-cycle vectors and compares the
// arbiter's outputs against hand-computed expectations. Expectations that
// depend on the arbitration mode follow the PM_ARB_RR_EN macro.
module tb_pm_arbiter;

`ifdef PM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // One cycle of stimulus plus expected outputs.
  // ef = expected {f_gnt, d_gnt, pm_rd, f_rvalid, d_rvalid}
  typedef struct packed {
    logic        fr;
    logic [31:0] fa;
    logic        fl;
    logic        dr;
    logic [31:0] da;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic [4:0]  ef;
    logic [31:0] ea;
    logic [2:0]  eo;
    logic        ee;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] outstanding;
  logic       err;
  int         n_checks = 0;
  int         n_fail   = 0;

  pm_arbiter_if #(.XLEN(32)) bus ();

  pm_arbiter #(.XLEN(32), .MAX_OUT(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus.slave),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  wire [4:0] obs = {bus.f_gnt_o, bus.d_gnt_o, bus.pm_rd_o, bus.f_rvalid_o, bus.d_rvalid_o};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic fr, input logic [31:0] fa, input logic fl,
                              input logic dr, input logic [31:0] da, input logic rdy,
                              input logic rv, input logic [31:0] rd, input logic [4:0] ef,
                              input logic [31:0] ea, input logic [2:0] eo, input logic ee);
    vec_t v;
    v = '{fr: fr, fa: fa, fl: fl, dr: dr, da: da, rdy: rdy, rv: rv, rd: rd,
          ef: ef, ea: ea, eo: eo, ee: ee};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    bus.f_req_i     = v.fr;
    bus.f_addr_i    = v.fa;
    bus.f_flush_i   = v.fl;
    bus.d_req_i     = v.dr;
    bus.d_addr_i    = v.da;
    bus.pm_ready_i  = v.rdy;
    bus.pm_rvalid_i = v.rv;
    bus.pm_rdata_i  = v.rd;
  endtask

  task automatic idle_inputs();
    apply('0);
  endtask

  // Synchronous-looking reset pulse; leaves time at posedge+1 with rst low.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;  // before the first clock edge: asynchronous reset must already act
    n_checks++;
    if (outstanding !== 3'd0) begin
      n_fail++; $display("FAIL reset.outstanding: got %0d want 0", outstanding);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL reset.err: got %b want 0", err);
    end
    n_checks++;
    if (obs !== 5'b00000) begin
      n_fail++; $display("FAIL reset.flags: got %b want 00000", obs);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    n_checks++;
    if ({outstanding, err, obs} !== 9'b0) begin
      n_fail++; $display("FAIL reset.after_release: got %b want 0", {outstanding, err, obs});
    end
    @(posedge clk);
    #1;
  endtask

  // Fetch alone, PM latency 2, addresses 0x0/0x4/0x8 after one not-ready cycle.
  task automatic test_fetch_alone();
    vec_t t[$];
    do_reset();
    //              fr   fa      fl dr da  rdy rv rd          ef        ea     eo  ee
    t.push_back(mk(1, 32'h0, 0, 0, 0, 0, 0, 0,           5'b00100, 32'h0, 0, 0));
    t.push_back(mk(1, 32'h0, 0, 0, 0, 1, 0, 0,           5'b10100, 32'h0, 0, 0));
    t.push_back(mk(1, 32'h4, 0, 0, 0, 1, 0, 0,           5'b10100, 32'h4, 1, 0));
    t.push_back(mk(1, 32'h8, 0, 0, 0, 1, 1, 32'hA000_00A0, 5'b10110, 32'h8, 2, 0));
    t.push_back(mk(0, 32'h0, 0, 0, 0, 1, 1, 32'hA000_00A4, 5'b00010, 32'h0, 2, 0));
    t.push_back(mk(0, 32'h0, 0, 0, 0, 1, 1, 32'hA000_00A8, 5'b00010, 32'h0, 1, 0));
    t.push_back(mk(0, 32'h0, 0, 0, 0, 1, 0, 0,           5'b00000, 32'h0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      #2;
      n_checks++;
      if (obs !== t[i].ef) begin
        n_fail++; $display("FAIL fetch_alone.flags[%0d]: got %b want %b", i, obs, t[i].ef);
      end
      n_checks++;
      if (outstanding !== t[i].eo || err !== t[i].ee) begin
        n_fail++; $display("FAIL fetch_alone.occ_err[%0d]: got %0d/%b want %0d/%b", i, outstanding, err, t[i].eo, t[i].ee);
      end
      if (t[i].ef[2]) begin
        n_checks++;
        if (bus.pm_addr_o !== t[i].ea) begin
          n_fail++; $display("FAIL fetch_alone.addr[%0d]: got %h want %h", i, bus.pm_addr_o, t[i].ea);
        end
      end
      if (t[i].ef[1]) begin
        n_checks++;
        if (bus.f_rdata_o !== t[i].rd) begin
          n_fail++; $display("FAIL fetch_alone.rdata[%0d]: got %h want %h", i, bus.f_rdata_o, t[i].rd);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Both requesting from reset; fill to MAX_OUT, one response, grant resumes.
  task automatic test_arbitration();
    vec_t t[$];
    logic [4:0] gf, gd, rsp;
    logic [31:0] af, ad;
    do_reset();
    gf  = RR ? 5'b10100 : 5'b01100;   // tie while `last`=data (or fixed priority)
    gd  = 5'b01100;
    af  = RR ? 32'h100 : 32'h200;
    ad  = 32'h200;
    rsp = RR ? 5'b00010 : 5'b00001;   // head tag is the first granted source
    t.push_back(mk(1, 32'h100, 0, 1, 32'h200, 1, 0, 0,           gf,       af, 0, 0));
    t.push_back(mk(1, 32'h100, 0, 1, 32'h200, 1, 0, 0,           gd,       ad, 1, 0));
    t.push_back(mk(1, 32'h100, 0, 1, 32'h200, 1, 0, 0,           gf,       af, 2, 0));
    t.push_back(mk(1, 32'h100, 0, 1, 32'h200, 1, 0, 0,           gd,       ad, 3, 0));
    t.push_back(mk(1, 32'h100, 0, 1, 32'h200, 1, 0, 0,           5'b00000, 0,  4, 0));
    t.push_back(mk(1, 32'h100, 0, 1, 32'h200, 1, 1, 32'h0000_00B0, rsp,     0,  4, 0));
    t.push_back(mk(1, 32'h100, 0, 1, 32'h200, 1, 0, 0,           gf,       af, 3, 0));
    t.push_back(mk(1, 32'h100, 0, 1, 32'h200, 1, 0, 0,           5'b00000, 0,  4, 0));
    foreach (t[i]) begin
      apply(t[i]);
      #2;
      n_checks++;
      if (obs !== t[i].ef) begin
        n_fail++; $display("FAIL arbitration.flags[%0d]: got %b want %b", i, obs, t[i].ef);
      end
      n_checks++;
      if (outstanding !== t[i].eo || err !== t[i].ee) begin
        n_fail++; $display("FAIL arbitration.occ_err[%0d]: got %0d/%b want %0d/%b", i, outstanding, err, t[i].eo, t[i].ee);
      end
      if (t[i].ef[2]) begin
        n_checks++;
        if (bus.pm_addr_o !== t[i].ea) begin
          n_fail++; $display("FAIL arbitration.addr[%0d]: got %h want %h", i, bus.pm_addr_o, t[i].ea);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // F, D, F issued, flush pulse, then a new fetch that must return normally.
  task automatic test_flush();
    vec_t t[$];
    do_reset();
    t.push_back(mk(1, 32'h10, 0, 0, 0,     1, 0, 0,           5'b10100, 32'h10, 0, 0));
    t.push_back(mk(0, 32'h0,  0, 1, 32'h20, 1, 0, 0,          5'b01100, 32'h20, 1, 0));
    t.push_back(mk(1, 32'h30, 0, 0, 0,     1, 0, 0,           5'b10100, 32'h30, 2, 0));
    t.push_back(mk(1, 32'h40, 1, 0, 0,     1, 0, 0,           5'b00000, 0,      3, 0));
    t.push_back(mk(1, 32'h40, 0, 0, 0,     1, 1, 32'h0000_00C0, 5'b10100, 32'h40, 3, 0));
    t.push_back(mk(0, 32'h0,  0, 0, 0,     1, 1, 32'h0000_00C1, 5'b00001, 0,      3, 0));
    t.push_back(mk(0, 32'h0,  0, 0, 0,     1, 1, 32'h0000_00C2, 5'b00000, 0,      2, 0));
    t.push_back(mk(0, 32'h0,  0, 0, 0,     1, 1, 32'h0000_00C3, 5'b00010, 0,      1, 0));
    t.push_back(mk(0, 32'h0,  0, 0, 0,     1, 0, 0,           5'b00000, 0,      0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      #2;
      n_checks++;
      if (obs !== t[i].ef) begin
        n_fail++; $display("FAIL flush.flags[%0d]: got %b want %b", i, obs, t[i].ef);
      end
      n_checks++;
      if (outstanding !== t[i].eo || err !== t[i].ee) begin
        n_fail++; $display("FAIL flush.occ_err[%0d]: got %0d/%b want %0d/%b", i, outstanding, err, t[i].eo, t[i].ee);
      end
      if (t[i].ef[0]) begin
        n_checks++;
        if (bus.d_rdata_o !== t[i].rd) begin
          n_fail++; $display("FAIL flush.d_rdata[%0d]: got %h want %h", i, bus.d_rdata_o, t[i].rd);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Flush in the same cycle as a fetch-tagged pop, fetch request held meanwhile.
  task automatic test_flush_pop();
    vec_t t[$];
    do_reset();
    t.push_back(mk(1, 32'h50, 0, 0, 0,      1, 0, 0,           5'b10100, 32'h50, 0, 0));
    t.push_back(mk(0, 32'h0,  0, 1, 32'h54, 1, 0, 0,           5'b01100, 32'h54, 1, 0));
    t.push_back(mk(1, 32'h58, 1, 0, 0,      1, 1, 32'h0000_00D0, 5'b00000, 0,      2, 0));
    t.push_back(mk(1, 32'h58, 0, 0, 0,      1, 1, 32'h0000_00D1, 5'b10101, 32'h58, 1, 0));
    t.push_back(mk(0, 32'h0,  0, 0, 0,      1, 1, 32'h0000_00D2, 5'b00010, 0,      1, 0));
    t.push_back(mk(0, 32'h0,  0, 0, 0,      1, 0, 0,           5'b00000, 0,      0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      #2;
      n_checks++;
      if (obs !== t[i].ef) begin
        n_fail++; $display("FAIL flush_pop.flags[%0d]: got %b want %b", i, obs, t[i].ef);
      end
      n_checks++;
      if (outstanding !== t[i].eo || err !== t[i].ee) begin
        n_fail++; $display("FAIL flush_pop.occ_err[%0d]: got %0d/%b want %0d/%b", i, outstanding, err, t[i].eo, t[i].ee);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Response with an empty FIFO sets a sticky error; only reset clears it.
  task automatic test_err();
    vec_t t[$];
    do_reset();
    t.push_back(mk(0, 32'h0,  0, 0, 0, 1, 1, 32'h0000_00EE, 5'b00000, 0,      0, 0));
    t.push_back(mk(1, 32'h60, 0, 0, 0, 1, 0, 0,           5'b10100, 32'h60, 0, 1));
    t.push_back(mk(0, 32'h0,  0, 0, 0, 1, 0, 0,           5'b00000, 0,      1, 1));
    t.push_back(mk(0, 32'h0,  0, 0, 0, 1, 1, 32'h0000_0061, 5'b00010, 0,      1, 1));
    t.push_back(mk(0, 32'h0,  0, 0, 0, 1, 0, 0,           5'b00000, 0,      0, 1));
    t.push_back(mk(1, 32'h64, 0, 0, 0, 1, 0, 0,           5'b10100, 32'h64, 0, 1));
    foreach (t[i]) begin
      apply(t[i]);
      #2;
      n_checks++;
      if (obs !== t[i].ef) begin
        n_fail++; $display("FAIL err.flags[%0d]: got %b want %b", i, obs, t[i].ef);
      end
      n_checks++;
      if (outstanding !== t[i].eo || err !== t[i].ee) begin
        n_fail++; $display("FAIL err.occ_err[%0d]: got %0d/%b want %0d/%b", i, outstanding, err, t[i].eo, t[i].ee);
      end
      @(posedge clk);
      #1;
    end
    // One fetch is in flight and err is set; reset asserted mid-cycle clears both.
    idle_inputs();
    rst = 1'b1;
    #1;
    n_checks++;
    if (outstanding !== 3'd0 || err !== 1'b0) begin
      n_fail++; $display("FAIL err.async_reset: got %0d/%b want 0/0", outstanding, err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_alone();
    test_arbitration();
    test_flush();
    test_flush_pop();
    test_err();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
